implication_resp_checker: RTL and testbench
===========================================

// Module: implication_resp_checker
// PURPOSE
//   Receive-side checker for the implication gate (out = ~a | b).
//   Accepts {a, b, dut_out} samples over a valid/ready handshake and compares each against the truth table.
//   Counts passes and failures, and tracks which of the 4 input combinations were seen.
//   Gives an on-chip pass/fail verdict, so the bench no longer depends on $display inspection.
// PARAMETERS
//   NUM_VEC  4  samples per run; legal range 1..2^CNT_W-1
//   CNT_W    8  width of pass/fail counters
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous reset, active-high
//   start       in   1      1-cycle pulse: clear results and begin a run
//   vec_valid   in   1      sample present on vec_a/vec_b/dut_out
//   vec_ready   out  1      checker can accept a sample
//   vec_a       in   1      gate input a
//   vec_b       in   1      gate input b
//   dut_out     in   1      gate output under test
//   pass_cnt    out  CNT_W  matching samples
//   fail_cnt    out  CNT_W  mismatching samples
//   coverage    out  4      bit {a,b} set once that combination has been checked
//   busy        out  1      state==RUN
//   done        out  1      state==DONE
//   all_pass    out  1      done & fail_cnt==0 & coverage==4'hF
// BEHAVIOUR
//   - Reset, asynchronous and active-high:
//     - state=IDLE; s1_vld=0; acc_cnt=0; chk_cnt=0.
//     - pass_cnt=0, fail_cnt=0, coverage=0; every output 0.
//     - Reset mid-run abandons the run; no partial result survives.
//   - FSM states: IDLE, RUN, DONE.
//     - IDLE --start--> RUN.
//     - RUN --last compare commits--> DONE.
//     - DONE --start--> RUN.
//     - start while in RUN restarts the run.
//   - Every start clears pass_cnt, fail_cnt, coverage, acc_cnt and chk_cnt, and flushes s1_vld.
//     - A handshake in the same cycle as start is ignored.
//   - vec_ready = (state==RUN) & (acc_cnt < NUM_VEC). It is never 1 in IDLE or DONE.
//   - A handshake is vec_valid & vec_ready at a rising edge.
//     - It captures {vec_a, vec_b, dut_out} into stage s1, sets s1_vld and increments acc_cnt.
//     - vec_valid while not ready is ignored; the sample is neither stored nor counted.
//   - Compare stage: on the edge after capture, when s1_vld:
//     - expected = ~a | b.
//     - Match increments pass_cnt; mismatch increments fail_cnt.
//     - coverage[{a,b}] is set and chk_cnt is incremented.
//   - Latency: counters reflect a sample 1 cycle after its acceptance edge.
//   - Back-to-back handshakes are supported at full rate, one sample per cycle.
//   - DONE is entered on the edge where chk_cnt reaches NUM_VEC, so done asserts 1 cycle after the last accept.
//   - Counters saturate at 2^CNT_W-1 and never wrap.
//   - Outputs hold their values in DONE until the next start or reset.
// CONFIGURATION
//   IMPL_CHK_FIRST_FAIL_EN
//     - Defined: adds output port first_fail (out, 4 bits) = {valid, a, b, dut_out}.
//       - It captures the first mismatching sample of the run.
//       - It is cleared by start or reset.
//       - Later mismatches do not overwrite it.
//     - Undefined: the port and its logic are absent; all other behaviour is identical.
// TESTING
//   1. Reset, start; send (0,0,1),(0,1,1),(1,0,0),(1,1,1) back-to-back
//      -> pass_cnt=4, fail_cnt=0, coverage=4'hF, done=1 and all_pass=1 one cycle after the last accept.
//   2. Same run but (1,0,1) in place of (1,0,0)
//      -> fail_cnt=1, pass_cnt=3, all_pass=0; with _EN: first_fail=4'b1101.
//   3. Send (0,0,1) four times -> pass_cnt=4, coverage=4'b0001, done=1, all_pass=0.
//   4. Drive vec_valid=1 in IDLE and in DONE -> vec_ready=0 and no counter changes.
//      - After 4 accepts in RUN, a 5th valid is not accepted.
//   5. Assert rst after 2 accepts -> all outputs 0 immediately, before the next clk edge.
//      - A new start plus 4 vectors completes normally.
//   6. Pulse start after 2 accepts -> counters clear; 4 further accepts are required before done.

Source files
------------

// File: rtl/implication_resp_checker.sv
// Receive-side checker for the implication gate (out = ~a | b): scores handshaked samples and
// reports pass/fail counts, input coverage and a verdict. Optional feature: IMPL_CHK_FIRST_FAIL_EN.
module implication_resp_checker #(
   parameter int NUM_VEC = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             vec_valid,
   output logic             vec_ready,
   input  logic             vec_a,
   input  logic             vec_b,
   input  logic             dut_out,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [3:0]       coverage,
   output logic             busy,
   output logic             done,
   output logic             all_pass
`ifdef IMPL_CHK_FIRST_FAIL_EN
   ,
   output logic [3:0]       first_fail
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [CNT_W-1:0] C_NUM_VEC = CNT_W'(NUM_VEC);
   localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_MAX     = '1;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_acc_cnt;
   logic [CNT_W-1:0] r_chk_cnt;
   logic [CNT_W-1:0] r_pass_cnt;
   logic [CNT_W-1:0] r_fail_cnt;
   logic [3:0]       r_coverage;
   logic             r_s1_vld;
   logic             r_s1_a;
   logic             r_s1_b;
   logic             r_s1_out;
   logic             w_accept;
   logic             w_match;
   logic             w_last_cmp;

   assign vec_ready  = (r_state == S_RUN) && (r_acc_cnt < C_NUM_VEC);
   // A handshake coinciding with start belongs to the abandoned run, so it is dropped.
   assign w_accept   = vec_valid & vec_ready & ~start;
   assign w_match    = (r_s1_out == (~r_s1_a | r_s1_b));
   assign w_last_cmp = r_s1_vld && (r_chk_cnt == C_NUM_VEC - C_ONE);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_RUN;
         S_RUN:   if (start) w_state_next = S_RUN;
                  else if (w_last_cmp) w_state_next = S_DONE;
         S_DONE:  if (start) w_state_next = S_RUN;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc_cnt  <= '0;
         r_chk_cnt  <= '0;
         r_pass_cnt <= '0;
         r_fail_cnt <= '0;
         r_coverage <= '0;
         r_s1_vld   <= 1'b0;
         r_s1_a     <= 1'b0;
         r_s1_b     <= 1'b0;
         r_s1_out   <= 1'b0;
      end else if (start) begin
         r_acc_cnt  <= '0;
         r_chk_cnt  <= '0;
         r_pass_cnt <= '0;
         r_fail_cnt <= '0;
         r_coverage <= '0;
         r_s1_vld   <= 1'b0;
      end else begin
         r_s1_vld <= w_accept;
         if (w_accept) begin
            r_s1_a    <= vec_a;
            r_s1_b    <= vec_b;
            r_s1_out  <= dut_out;
            r_acc_cnt <= r_acc_cnt + C_ONE;
         end
         if (r_s1_vld) begin
            if (w_match) begin
               if (r_pass_cnt != C_MAX) r_pass_cnt <= r_pass_cnt + C_ONE;
            end else begin
               if (r_fail_cnt != C_MAX) r_fail_cnt <= r_fail_cnt + C_ONE;
            end
            r_coverage[{r_s1_a, r_s1_b}] <= 1'b1;
            if (r_chk_cnt != C_MAX) r_chk_cnt <= r_chk_cnt + C_ONE;
         end
      end
   end

`ifdef IMPL_CHK_FIRST_FAIL_EN
   logic [3:0] r_first_fail;

   // Bit 3 doubles as the "already captured" flag so later mismatches cannot overwrite.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_first_fail <= '0;
      else if (start)
         r_first_fail <= '0;
      else if (r_s1_vld && !w_match && !r_first_fail[3])
         r_first_fail <= {1'b1, r_s1_a, r_s1_b, r_s1_out};
   end

   assign first_fail = r_first_fail;
`endif

   assign pass_cnt = r_pass_cnt;
   assign fail_cnt = r_fail_cnt;
   assign coverage = r_coverage;
   assign busy     = (r_state == S_RUN);
   assign done     = (r_state == S_DONE);
   assign all_pass = done && (r_fail_cnt == '0) && (r_coverage == 4'hF);

endmodule

// File: tb/tb_implication_resp_checker.sv
// Directed bench for implication_resp_checker: stimulus pushes hand-computed run results,
// a monitor pops and compares them whenever done rises.
module tb_implication_resp_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       vec_valid;
   logic       vec_ready;
   logic       vec_a;
   logic       vec_b;
   logic       dut_out;
   logic [7:0] pass_cnt;
   logic [7:0] fail_cnt;
   logic [3:0] coverage;
   logic       busy;
   logic       done;
   logic       all_pass;
`ifdef IMPL_CHK_FIRST_FAIL_EN
   logic [3:0] first_fail;
`endif

   implication_resp_checker #(.NUM_VEC(4), .CNT_W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .vec_valid (vec_valid),
      .vec_ready (vec_ready),
      .vec_a     (vec_a),
      .vec_b     (vec_b),
      .dut_out   (dut_out),
      .pass_cnt  (pass_cnt),
      .fail_cnt  (fail_cnt),
      .coverage  (coverage),
      .busy      (busy),
      .done      (done),
      .all_pass  (all_pass)
`ifdef IMPL_CHK_FIRST_FAIL_EN
      ,
      .first_fail(first_fail)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] pass_n;
      logic [7:0] fail_n;
      logic [3:0] cov;
      logic       ap;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_runs   = 0;
   logic prev_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   task automatic drive(input logic v, input logic [2:0] s);
      vec_valid = v;
      {vec_a, vec_b, dut_out} = s;
   endtask

   // Called at a negedge; returns at the negedge after the start edge.
   task automatic pulse_start(input logic v, input logic [2:0] s);
      start = 1'b1;
      drive(v, s);
      @(negedge clk);
      start = 1'b0;
      drive(1'b0, 3'b000);
   endtask

   // Sends vectors v[3], v[2], ... back-to-back; returns at the negedge after the last accept.
   task automatic run_vecs(input logic [3:0][2:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, v[3-i]);
         chk($sformatf("ready_before_accept%0d", i), vec_ready, 1'b1);
         @(negedge clk);
      end
   endtask

   // Holds a mismatching 5th vector that must be refused, then expects done one cycle after the last accept.
   task automatic tail();
      drive(1'b1, 3'b000);
      chk("ready_after_4_accepts", vec_ready, 1'b0);
      chk("done_not_yet", done, 1'b0);
      @(negedge clk);
      chk("done_one_cycle_after_last", done, 1'b1);
      drive(1'b0, 3'b000);
   endtask

   // Monitor: one expected result per completed run.
   always @(negedge clk) begin
      if (rst) begin
         prev_done = 1'b0;
      end else begin
         if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1'b1, 1'b0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk($sformatf("run%0d_pass_cnt", n_runs), pass_cnt, e.pass_n);
               chk($sformatf("run%0d_fail_cnt", n_runs), fail_cnt, e.fail_n);
               chk($sformatf("run%0d_coverage", n_runs), coverage, e.cov);
               chk($sformatf("run%0d_all_pass", n_runs), all_pass, e.ap);
               $display("run %0d: pass=%0d fail=%0d cov=%b all_pass=%b", n_runs, pass_cnt, fail_cnt, coverage, all_pass);
               n_runs++;
            end
         end
         prev_done = done;
      end
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      drive(1'b0, 3'b000);
      repeat (2) @(negedge clk);
      chk("rst_ready", vec_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_all_pass", all_pass, 1'b0);
      chk("rst_pass_cnt", pass_cnt, 8'd0);
      chk("rst_fail_cnt", fail_cnt, 8'd0);
      chk("rst_coverage", coverage, 4'h0);
`ifdef IMPL_CHK_FIRST_FAIL_EN
      chk("rst_first_fail", first_fail, 4'h0);
`endif
      rst = 1'b0;

      // valid in IDLE is ignored
      drive(1'b1, 3'b001);
      @(negedge clk);
      chk("idle_ready", vec_ready, 1'b0);
      chk("idle_pass_cnt", pass_cnt, 8'd0);
      chk("idle_busy", busy, 1'b0);
      drive(1'b0, 3'b000);

      // full truth table, all correct
      exp_q.push_back('{8'd4, 8'd0, 4'hF, 1'b1});
      pulse_start(1'b0, 3'b000);
      chk("run_busy", busy, 1'b1);
      run_vecs({3'b001, 3'b011, 3'b100, 3'b111}, 4);
      tail();

      // valid in DONE is ignored and results hold
      drive(1'b1, 3'b011);
      @(negedge clk);
      chk("done_ready", vec_ready, 1'b0);
      chk("done_hold_pass_cnt", pass_cnt, 8'd4);
      chk("done_hold_done", done, 1'b1);
      chk("done_hold_all_pass", all_pass, 1'b1);
      drive(1'b0, 3'b000);

      // one wrong response: (1,0) should give 0
      exp_q.push_back('{8'd3, 8'd1, 4'hF, 1'b0});
      pulse_start(1'b0, 3'b000);
      run_vecs({3'b001, 3'b011, 3'b101, 3'b111}, 4);
      tail();
`ifdef IMPL_CHK_FIRST_FAIL_EN
      chk("first_fail_capture", first_fail, 4'b1101);
`endif

      // correct but incomplete coverage
      exp_q.push_back('{8'd4, 8'd0, 4'b0001, 1'b0});
      pulse_start(1'b0, 3'b000);
`ifdef IMPL_CHK_FIRST_FAIL_EN
      chk("first_fail_cleared_by_start", first_fail, 4'h0);
`endif
      run_vecs({3'b001, 3'b001, 3'b001, 3'b001}, 4);
      tail();

      // asynchronous reset mid-run
      pulse_start(1'b0, 3'b000);
      run_vecs({3'b100, 3'b100, 3'b000, 3'b000}, 2);
      chk("pre_reset_pass_cnt", pass_cnt, 8'd1);
      drive(1'b0, 3'b000);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_pass_cnt", pass_cnt, 8'd0);
      chk("async_rst_coverage", coverage, 4'h0);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_ready", vec_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back('{8'd4, 8'd0, 4'hF, 1'b1});
      pulse_start(1'b0, 3'b000);
      run_vecs({3'b001, 3'b011, 3'b100, 3'b111}, 4);
      tail();

      // restart mid-run; handshake in the start cycle must be dropped
      pulse_start(1'b0, 3'b000);
      run_vecs({3'b101, 3'b101, 3'b000, 3'b000}, 2);
      chk("pre_restart_fail_cnt", fail_cnt, 8'd1);
      exp_q.push_back('{8'd4, 8'd0, 4'hF, 1'b1});
      pulse_start(1'b1, 3'b110);
      chk("restart_fail_cnt", fail_cnt, 8'd0);
      chk("restart_pass_cnt", pass_cnt, 8'd0);
`ifdef IMPL_CHK_FIRST_FAIL_EN
      chk("restart_first_fail", first_fail, 4'h0);
`endif
      run_vecs({3'b001, 3'b011, 3'b100, 3'b111}, 4);
      tail();

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("runs_completed", n_runs, 5);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
